// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: display reads have absolute priority and
// return a registered pixel colour 3 clk after pix_en; host writes fill idle slots.
module vram_arbiter #(
  parameter int FB_W          = 160,
  parameter int FB_H          = 120,
  parameter int WR_BLANK_ONLY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [15:0] CELLS_C = 16'(FB_W * FB_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DREAD = 2'd1,
    DCAPT = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        wr_ack_q, wr_ack_d;
  logic [7:0]  rgb_q, rgb_d;
  logic [1:0]  blank_q, blank_d;
  logic [2:0]  hs_q, vs_q;

  logic [14:0] disp_addr_s;
  logic        wr_in_range_s;
  logic        wr_allow_s;
  logic        grant_s;
  logic        take_pix_s;
  logic        unused_s;

  // Row base = row * FB_W as a sum of constant shifts of the row index.
  function automatic logic [14:0] row_base(input logic [7:0] row);
    logic [14:0] acc;
    acc = 15'd0;
    for (int i = 0; i < 15; i++) begin
      if (FB_W[i]) acc = acc + ({7'd0, row} << i);
    end
    return acc;
  endfunction

  assign disp_addr_s   = row_base(pixel_y[9:2]) + {7'd0, pixel_x[9:2]};
  assign wr_in_range_s = ({1'b0, wr_addr} < CELLS_C);
  assign wr_allow_s    = (WR_BLANK_ONLY == 0) || !video_on;
  assign grant_s       = (state_q == IDLE) && !pix_en && wr_req && !wr_ack_q && wr_allow_s;
  // A pixel may arrive the cycle after a write grant, so WRITE also accepts it.
  assign take_pix_s    = pix_en && ((state_q == IDLE) || (state_q == WRITE));
  assign unused_s      = ^{pixel_x[1:0], pixel_y[1:0]};

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    rgb_d       = rgb_q;
    blank_d     = {blank_q[0], take_pix_s && !video_on};
    case (state_q)
      IDLE: begin
        if (take_pix_s && video_on) begin
          state_d    = DREAD;
          mem_addr_d = disp_addr_s;
        end else if (grant_s) begin
          state_d     = WRITE;
          mem_addr_d  = wr_addr;
          mem_wdata_d = wr_data;
          mem_we_d    = wr_in_range_s;
          wr_ack_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DREAD: state_d = DCAPT;
      DCAPT: begin
        state_d = IDLE;
        rgb_d   = mem_rdata;
      end
      WRITE: begin
        if (take_pix_s && video_on) begin
          state_d    = DREAD;
          mem_addr_d = disp_addr_s;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (blank_q[1]) begin
      rgb_d = 8'd0;
    end else begin
      rgb_d = rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= 15'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      wr_ack_q    <= 1'b0;
      rgb_q       <= 8'd0;
      blank_q     <= 2'd0;
      hs_q        <= 3'd0;
      vs_q        <= 3'd0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rgb_q       <= rgb_d;
      blank_q     <= blank_d;
      hs_q        <= {hs_q[1:0], hsync_in};
      vs_q        <= {vs_q[1:0], vsync_in};
    end
  end

  assign wr_ack    = wr_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q[2];
  assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: cycle-level scoreboard built from the arbitration
// rules, plus directed scenarios with hand-computed expectations.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = 15'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_ack, mem_we, hsync_out, vsync_out;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, rgb;
  logic [7:0]  mem_rdata = 8'd0;

  logic        b_wr_ack, b_mem_we, b_hsync_out, b_vsync_out;
  logic [14:0] b_mem_addr;
  logic [7:0]  b_mem_wdata, b_rgb;

  int errs = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  vram_arbiter #(.WR_BLANK_ONLY(1)) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(b_wr_ack), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(8'h00), .rgb(b_rgb),
    .hsync_out(b_hsync_out), .vsync_out(b_vsync_out)
  );

  // Synchronous single-port RAM attached to the main DUT.
  logic [7:0] ram [32768];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: edge n samples the inputs; history arrays say what the RAM port was doing.
  logic [7:0]  mdl_ram [32768];
  bit          disp_at [4096];
  bit          grant_at [4096];
  bit          sched_on [4096];
  logic [7:0]  sched_v [4096];
  logic        hs_at [4096];
  logic        vs_at [4096];
  int          n = 8;
  logic [7:0]  m_rgb = 8'd0, m_wdata = 8'd0;
  logic [14:0] m_addr = 15'd0;
  logic        m_we = 1'b0, m_ack = 1'b0, m_hs = 1'b0, m_vs = 1'b0;

  always @(posedge clk) begin
    int da;
    n = n + 1;
    da = (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        hs_at[n-k] = 1'b0; vs_at[n-k] = 1'b0;
        disp_at[n-k] = 1'b0; grant_at[n-k] = 1'b0;
      end
      sched_on[n+1] = 1'b0; sched_on[n+2] = 1'b0;
      m_rgb = 8'd0; m_wdata = 8'd0; m_addr = 15'd0;
      m_we = 1'b0; m_ack = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
    end else begin
      hs_at[n] = hsync_in; vs_at[n] = vsync_in;
      m_hs = hs_at[n-2]; m_vs = vs_at[n-2];
      if (sched_on[n]) m_rgb = sched_v[n];
      disp_at[n]  = pix_en && video_on;
      grant_at[n] = !pix_en && wr_req && !grant_at[n-1] && !disp_at[n-1] && !disp_at[n-2];
      m_ack = grant_at[n];
      m_we  = 1'b0;
      if (pix_en) begin
        sched_on[n+2] = 1'b1;
        sched_v[n+2]  = video_on ? mdl_ram[da] : 8'd0;
      end
      if (disp_at[n]) m_addr = 15'(da);
      if (grant_at[n]) begin
        m_addr = wr_addr; m_wdata = wr_data;
        if (int'(wr_addr) < 160 * 120) begin
          m_we = 1'b1;
          mdl_ram[wr_addr] = wr_data;
        end
      end
    end
  end

  // Every-cycle comparison against the scoreboard.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rgb", rgb, m_rgb);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("wr_ack", wr_ack, m_ack);
      chk("hsync_out", hsync_out, m_hs);
      chk("vsync_out", vsync_out, m_vs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic vid);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid; pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 32768; i++) begin
      ram[i] = 8'd0; mdl_ram[i] = 8'd0;
    end
    ram[161] = 8'hE3;  mdl_ram[161] = 8'hE3;
    ram[1625] = 8'h5A; mdl_ram[1625] = 8'h5A;

    repeat (3) tick();
    chk_on = 1'b1;
    chk("reset_rgb", rgb, 8'd0);
    chk("reset_ack", wr_ack, 1'b0);
    chk("reset_addr", mem_addr, 15'd0);
    reset = 1'b0;
    tick();

    // Scenario A
    pixel_x = 10'd4; pixel_y = 10'd4; video_on = 1'b1; pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("A_addr", mem_addr, 15'd161);
    chk("A_we", mem_we, 1'b0);
    tick();
    chk("A_rgb_early", rgb, 8'd0);
    tick();
    chk("A_rgb", rgb, 8'hE3);
    tick();
    pixel(100, 40, 1'b1);
    chk("A2_rgb", rgb, 8'h5A);
    pixel(100, 40, 1'b0);
    chk("blank_rgb", rgb, 8'h00);
    pixel(799, 479, 1'b1);

    // Scenario B
    video_on = 1'b0;
    wr_addr = 15'd5; wr_data = 8'h1C; wr_req = 1'b1;
    tick();
    chk("B_we", mem_we, 1'b1);
    chk("B_addr", mem_addr, 15'd5);
    chk("B_ack", wr_ack, 1'b1);
    tick();
    chk("B_no_second_we", mem_we, 1'b0);
    chk("B_no_second_ack", wr_ack, 1'b0);
    wr_req = 1'b0;
    tick();
    pixel(20, 0, 1'b1);
    chk("B_readback", rgb, 8'h1C);

    // Scenario C
    pixel_x = 10'd4; pixel_y = 10'd4; video_on = 1'b1; pix_en = 1'b1;
    wr_addr = 15'd7; wr_data = 8'h33; wr_req = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("C_read_first", mem_addr, 15'd161);
    lat = 1;
    while (!mem_we && lat < 8) begin
      tick();
      lat++;
    end
    chk("C_write_latency", lat, 4);
    wr_req = 1'b0;
    repeat (2) tick();

    // Scenario E
    wr_addr = 15'd19200; wr_data = 8'hFF; wr_req = 1'b1; video_on = 1'b0;
    tick();
    chk("E_ack", wr_ack, 1'b1);
    chk("E_we_dropped", mem_we, 1'b0);
    wr_req = 1'b0;
    tick();
    chk("E_we_after", mem_we, 1'b0);
    wr_addr = 15'd19199; wr_data = 8'h81; wr_req = 1'b1;
    tick();
    chk("E_last_cell_we", mem_we, 1'b1);
    wr_req = 1'b0;
    repeat (2) tick();

    // Scenario D: blank-only instance must hold off while video is on
    video_on = 1'b1; wr_addr = 15'd9; wr_data = 8'h44; wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("D_no_ack", b_wr_ack, 1'b0);
    end
    video_on = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!b_wr_ack && lat < 2);
    chk("D_ack_in_blank", b_wr_ack, 1'b1);
    chk("D_we_in_blank", b_mem_we, 1'b1);
    wr_req = 1'b0;
    repeat (3) tick();

    // Sync pipeline with mixed patterns
    for (int i = 0; i < 12; i++) begin
      hsync_in = 1'((i * 5 + 1) % 3 == 0);
      vsync_in = 1'(i % 4 == 1);
      tick();
    end
    hsync_in = 1'b1; vsync_in = 1'b1;

    // Scenario F: reset lands on the write-grant edge
    wr_addr = 15'd11; wr_data = 8'h77; wr_req = 1'b1; reset = 1'b1;
    tick();
    chk("F_no_we", mem_we, 1'b0);
    chk("F_no_ack", wr_ack, 1'b0);
    chk("F_rgb", rgb, 8'd0);
    chk("F_hsync", hsync_out, 1'b0);
    wr_req = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    tick();
    chk("F_hs_delay_early", hsync_out, 1'b0);
    tick();
    chk("F_hs_delay", hsync_out, 1'b1);

    // Reset with a display read in flight discards it
    pixel_x = 10'd4; pixel_y = 10'd4; video_on = 1'b1; pix_en = 1'b1;
    tick();
    pix_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("F_read_discarded", rgb, 8'd0);
    repeat (4) tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
